// File: rtl/blk_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// blk_alloc_ctrl
//
// Allocation / free controller for the bit-map free-block table of the
// multi-port cache. It accepts multi-block allocation requests from the
// packet writer. It hands out the table's lowest free block one at a time
// and marks each one used through table write port 1. Block-free requests
// from the read side are queued in a small FIFO and cleared through table
// write port 2.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   alloc_req       : allocation request, held until alloc_ack / alloc_err
//   alloc_num       : number of blocks requested (1..MAX_BLK)
//   alloc_ack       : one-cycle pulse, request accepted
//   alloc_err       : one-cycle pulse, request rejected (bad alloc_num)
//   alloc_addr      : granted block address
//   alloc_addr_vld  : one-cycle pulse per granted block
//   alloc_done      : pulse together with the last grant of a request
//   busy            : request in progress
//   free_req        : free request, accepted while free_ready=1
//   free_addr       : block address to free
//   free_ready      : free FIFO not full
//   emp_ready_addr  : table lowest free address
//   emp_ready_vld   : table lowest free address valid
//   emp_addr_num    : table free block count
//   wr_en_1/wr_addr_1/wr_val_1 : table claim write port
//   wr_en_2/wr_addr_2/wr_val_2 : table free write port
// ---------------------------------------------------------------------------
module blk_alloc_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 128,
  parameter int MAX_BLK         = 32,
  parameter int SETTLE_CYC      = 3,
  parameter int FREE_FIFO_DEPTH = 4,
  localparam int ADDR_W         = $clog2(DEPTH) + $clog2(WIDTH),
  localparam int NUM_W          = $clog2(MAX_BLK + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  input  logic [NUM_W-1:0]  alloc_num,
  output logic              alloc_ack,
  output logic              alloc_err,
  output logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_addr_vld,
  output logic              alloc_done,
  output logic              busy,
  input  logic              free_req,
  input  logic [ADDR_W-1:0] free_addr,
  output logic              free_ready,
  input  logic [ADDR_W-1:0] emp_ready_addr,
  input  logic              emp_ready_vld,
  input  logic [ADDR_W:0]   emp_addr_num,
  output logic              wr_en_1,
  output logic [ADDR_W-1:0] wr_addr_1,
  output logic              wr_val_1,
  output logic              wr_en_2,
  output logic [ADDR_W-1:0] wr_addr_2,
  output logic              wr_val_2
);

  localparam int SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int PTR_W = $clog2(FREE_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FNUM_W = ADDR_W + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ALLOC = 1'b1;

  logic [0:0]        state;
  logic [SET_W-1:0]  settle_cnt;
  logic [NUM_W-1:0]  remaining;

  logic [ADDR_W-1:0] fifo_mem [FREE_FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  cnt_next;

  logic num_ok;
  logic enough;
  logic grant;
  logic push;
  logic pop;

  // The table only commits a block after its address pipeline settles, so a
  // grant needs the settle counter expired as well as a valid free address.
  // Free writes yield to claims because the table miscounts simultaneous
  // writes on its two ports.
  always_comb begin
    num_ok   = (alloc_num != '0) && (alloc_num <= NUM_W'(MAX_BLK));
    enough   = emp_addr_num >= FNUM_W'(alloc_num);
    grant    = (state == ALLOC) && (settle_cnt == '0) && emp_ready_vld;
    push     = free_req && free_ready;
    pop      = (fifo_cnt != '0) && !grant;
    cnt_next = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
  end

  // Request admission, grant sequencing and claim writes. alloc_err blocks
  // re-evaluation for one cycle, so a requester that is still holding
  // alloc_req while it sees the error pulse gets exactly one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      settle_cnt     <= '0;
      remaining      <= '0;
      alloc_ack      <= 1'b0;
      alloc_err      <= 1'b0;
      alloc_addr     <= '0;
      alloc_addr_vld <= 1'b0;
      alloc_done     <= 1'b0;
      wr_en_1        <= 1'b0;
      wr_addr_1      <= '0;
      wr_val_1       <= 1'b0;
    end else begin
      alloc_ack      <= 1'b0;
      alloc_err      <= 1'b0;
      alloc_addr_vld <= 1'b0;
      alloc_done     <= 1'b0;
      wr_en_1        <= 1'b0;
      wr_val_1       <= 1'b0;

      // The counter runs down in every state, so a request that starts
      // right after a done still waits out the previous claim.
      if (grant) begin
        settle_cnt <= SET_W'(SETTLE_CYC);
      end else if (settle_cnt != '0) begin
        settle_cnt <= settle_cnt - SET_W'(1);
      end

      case (state)
        IDLE: begin
          if (alloc_req && !alloc_err) begin
            if (!num_ok) begin
              alloc_err <= 1'b1;
            end else if (enough) begin
              alloc_ack <= 1'b1;
              remaining <= alloc_num;
              state     <= ALLOC;
              busy      <= 1'b1;
            end
          end
        end
        ALLOC: begin
          if (grant) begin
            alloc_addr_vld <= 1'b1;
            alloc_addr     <= emp_ready_addr;
            wr_en_1        <= 1'b1;
            wr_addr_1      <= emp_ready_addr;
            wr_val_1       <= 1'b1;
            remaining      <= remaining - NUM_W'(1);
            if (remaining == NUM_W'(1)) begin
              alloc_done <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Free FIFO storage; contents need no reset because the pointers and count
  // define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= free_addr;
    end
  end

  // Free FIFO control and table free writes. free_ready is computed from the
  // next count so it is a plain register; a push offered while full is
  // refused even if a pop happens on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      free_ready <= 1'b1;
      wr_en_2    <= 1'b0;
      wr_addr_2  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      wr_en_2 <= pop;
      if (pop) begin
        wr_addr_2 <= fifo_mem[rd_ptr];
        rd_ptr    <= rd_ptr + PTR_W'(1);
      end
      fifo_cnt   <= cnt_next;
      free_ready <= (cnt_next != CNT_W'(FREE_FIFO_DEPTH));
    end
  end

  assign wr_val_2 = 1'b0;

endmodule

// File: tb/tb_blk_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_blk_alloc_ctrl
//
// Directed testbench for blk_alloc_ctrl. A behavioural bit-map table, 1024
// blocks with a combinational lowest-free search, closes the loop. Inputs
// change on the falling edge, and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_blk_alloc_ctrl;

  localparam int ADDR_W = 10;
  localparam int NUM_W  = 6;
  localparam int NBLK   = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_req;
  logic [NUM_W-1:0]  alloc_num;
  logic              alloc_ack;
  logic              alloc_err;
  logic [ADDR_W-1:0] alloc_addr;
  logic              alloc_addr_vld;
  logic              alloc_done;
  logic              busy;
  logic              free_req;
  logic [ADDR_W-1:0] free_addr;
  logic              free_ready;
  logic [ADDR_W-1:0] emp_ready_addr;
  logic              emp_ready_vld;
  logic [ADDR_W:0]   emp_addr_num;
  logic              wr_en_1;
  logic [ADDR_W-1:0] wr_addr_1;
  logic              wr_val_1;
  logic              wr_en_2;
  logic [ADDR_W-1:0] wr_addr_2;
  logic              wr_val_2;

  int compared   = 0;
  int mismatched = 0;
  int both_high  = 0;
  int bad_val    = 0;
  logic [ADDR_W-1:0] free_log [$];

  logic [NBLK-1:0] used;
  logic [NBLK-1:0] fill_val;
  logic            do_fill;

  blk_alloc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req      (alloc_req),
    .alloc_num      (alloc_num),
    .alloc_ack      (alloc_ack),
    .alloc_err      (alloc_err),
    .alloc_addr     (alloc_addr),
    .alloc_addr_vld (alloc_addr_vld),
    .alloc_done     (alloc_done),
    .busy           (busy),
    .free_req       (free_req),
    .free_addr      (free_addr),
    .free_ready     (free_ready),
    .emp_ready_addr (emp_ready_addr),
    .emp_ready_vld  (emp_ready_vld),
    .emp_addr_num   (emp_addr_num),
    .wr_en_1        (wr_en_1),
    .wr_addr_1      (wr_addr_1),
    .wr_val_1       (wr_val_1),
    .wr_en_2        (wr_en_2),
    .wr_addr_2      (wr_addr_2),
    .wr_val_2       (wr_val_2)
  );

  always #5 clk = ~clk;

  // Table model: the bench can preset the whole bitmap; otherwise the
  // claim and free writes from the controller update it.
  always @(posedge clk) begin
    if (do_fill) begin
      used <= fill_val;
    end else begin
      if (wr_en_1) used[wr_addr_1] <= 1'b1;
      if (wr_en_2) used[wr_addr_2] <= 1'b0;
    end
  end

  always_comb begin
    emp_ready_vld  = 1'b0;
    emp_ready_addr = '0;
    for (int i = NBLK - 1; i >= 0; i--) begin
      if (!used[i]) begin
        emp_ready_vld  = 1'b1;
        emp_ready_addr = ADDR_W'(i);
      end
    end
    emp_addr_num = (ADDR_W + 1)'(NBLK - $countones(used));
  end

  // Write-port monitor that runs for the whole simulation.
  always @(negedge clk) begin
    if (wr_en_1 && wr_en_2) both_high++;
    if (wr_en_1 && !wr_val_1) bad_val++;
    if (wr_en_2) begin
      free_log.push_back(wr_addr_2);
      if (wr_val_2) bad_val++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [NUM_W-1:0] num,
                               input logic freq, input logic [ADDR_W-1:0] faddr);
    alloc_req = req;
    alloc_num = num;
    free_req  = freq;
    free_addr = faddr;
  endtask

  task automatic fillTable(input logic [NBLK-1:0] val);
    fill_val = val;
    do_fill  = 1'b1;
    @(negedge clk);
    do_fill  = 1'b0;
  endtask

  task automatic waitAck(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (alloc_ack) got = 1'b1;
    end
  endtask

  // Expects num grants at consecutive addresses from first_addr. The first
  // grant comes first_lat cycles after the call, and later grants follow at
  // 4-cycle spacing.
  task automatic collectGrants(input int num, input int first_addr, input int first_lat, input string tag);
    int seen     = 0;
    int cyc      = 0;
    int last_cyc = 0;
    bit spacing_ok = 1'b1;
    while (seen < num && cyc < num * 8 + 8) begin
      @(negedge clk);
      cyc++;
      if (alloc_addr_vld) begin
        if (seen == 0) checkOutput({tag, "_first_lat"}, cyc, first_lat);
        else if (cyc - last_cyc != 4) spacing_ok = 1'b0;
        checkOutput({tag, "_addr"}, alloc_addr, first_addr + seen);
        checkOutput({tag, "_wr_en_1"}, wr_en_1, 1);
        checkOutput({tag, "_wr_addr_1"}, wr_addr_1, first_addr + seen);
        checkOutput({tag, "_done"}, alloc_done, (seen == num - 1) ? 1 : 0);
        last_cyc = cyc;
        seen++;
      end
    end
    checkOutput({tag, "_grants"}, seen, num);
    checkOutput({tag, "_spacing"}, spacing_ok, 1);
    checkOutput({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    bit got;
    bit saw_ack;
    bit saw_full;
    int n;
    int start;
    int accepted;
    int grants;

    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    fill_val = '0;
    do_fill  = 1'b1;
    repeat (3) @(negedge clk);
    do_fill = 1'b0;

    // Reset state
    checkOutput("rst_ack", alloc_ack, 0);
    checkOutput("rst_err", alloc_err, 0);
    checkOutput("rst_vld", alloc_addr_vld, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_free_ready", free_ready, 1);
    checkOutput("rst_wr_en", {30'd0, wr_en_1, wr_en_2}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic allocation of 3 blocks from an empty table
    applyStimulus(1'b1, 6'd3, 1'b0, '0);
    waitAck(5, got);
    checkOutput("basic_ack", got, 1);
    checkOutput("basic_busy", busy, 1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    collectGrants(3, 0, 1, "basic");

    // Invalid counts 0 and 33
    applyStimulus(1'b1, 6'd0, 1'b0, '0);
    @(negedge clk);
    checkOutput("err0_err", alloc_err, 1);
    checkOutput("err0_ack", alloc_ack, 0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("err0_pulse", alloc_err, 0);
    applyStimulus(1'b1, 6'd33, 1'b0, '0);
    @(negedge clk);
    checkOutput("err33_err", alloc_err, 1);
    checkOutput("err33_ack", alloc_ack, 0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (wr_en_1 || busy || alloc_ack) n++;
    end
    checkOutput("err_no_activity", n, 0);

    // Only blocks 100 and 101 free: 5 blocks must wait for three frees
    fill_val = '1;
    fill_val[100] = 1'b0;
    fill_val[101] = 1'b0;
    fillTable(fill_val);
    applyStimulus(1'b1, 6'd5, 1'b0, '0);
    saw_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (alloc_ack || busy) saw_ack = 1'b1;
    end
    checkOutput("held_no_ack", saw_ack, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 6'd5, 1'b1, ADDR_W'(102 + i));
      @(negedge clk);
    end
    applyStimulus(1'b1, 6'd5, 1'b0, '0);
    waitAck(20, got);
    checkOutput("held_ack", got, 1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    collectGrants(5, 100, 1, "held");

    // Four back-to-back frees while idle
    fillTable('0);
    start = free_log.size();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, ADDR_W'(7 + 2 * i));
      @(negedge clk);
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    repeat (8) @(negedge clk);
    checkOutput("idle_free_count", free_log.size() - start, 4);
    for (int i = 0; i < 4 && start + i < free_log.size(); i++) begin
      checkOutput("idle_free_addr", free_log[start + i], 7 + 2 * i);
    end

    // Free queued during the first grant cycle is stalled by one cycle
    applyStimulus(1'b1, 6'd2, 1'b1, ADDR_W'(500));
    @(negedge clk);
    checkOutput("prio_ack", alloc_ack, 1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("prio_grant_wr_en_1", wr_en_1, 1);
    checkOutput("prio_grant_wr_en_2", wr_en_2, 0);
    checkOutput("prio_grant_addr", alloc_addr, 0);
    @(negedge clk);
    checkOutput("prio_next_wr_en_1", wr_en_1, 0);
    checkOutput("prio_next_wr_en_2", wr_en_2, 1);
    checkOutput("prio_next_wr_addr_2", wr_addr_2, 500);
    collectGrants(1, 1, 3, "prio");

    // Continuous frees during an 8-block allocation fill the FIFO
    fillTable('0);
    start    = free_log.size();
    accepted = 0;
    grants   = 0;
    saw_full = 1'b0;
    applyStimulus(1'b1, 6'd8, 1'b1, ADDR_W'(600));
    for (int i = 0; i < 70; i++) begin
      bit will_accept;
      will_accept = free_req && free_ready;
      if (!free_ready) saw_full = 1'b1;
      @(negedge clk);
      if (alloc_ack) alloc_req = 1'b0;
      if (alloc_addr_vld) grants++;
      if (will_accept) begin
        accepted++;
        free_addr = ADDR_W'(600 + accepted);
      end
      if (accepted == 14) free_req = 1'b0;
    end
    checkOutput("fill_saw_full", saw_full, 1);
    checkOutput("fill_grants", grants, 8);
    checkOutput("fill_free_count", free_log.size() - start, accepted);
    n = 0;
    for (int i = 0; i < accepted && start + i < free_log.size(); i++) begin
      if (free_log[start + i] != ADDR_W'(600 + i)) n++;
    end
    checkOutput("fill_free_order", n, 0);
    checkOutput("fill_ready_end", free_ready, 1);

    // Reset after 1 of 4 grants, with one free still queued
    fillTable('0);
    applyStimulus(1'b1, 6'd4, 1'b0, '0);
    waitAck(5, got);
    checkOutput("mid_ack", got, 1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("mid_first_grant", alloc_addr_vld, 1);
    applyStimulus(1'b0, '0, 1'b1, ADDR_W'(700));
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, '0);
    rst   = 1'b1;
    start = free_log.size();
    @(negedge clk);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_vld", alloc_addr_vld, 0);
    checkOutput("mid_rst_addr", alloc_addr, 0);
    checkOutput("mid_rst_wr", {30'd0, wr_en_1, wr_en_2}, 0);
    checkOutput("mid_rst_wr_addr_1", wr_addr_1, 0);
    checkOutput("mid_rst_free_ready", free_ready, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mid_fifo_empty", free_log.size() - start, 0);
    applyStimulus(1'b1, 6'd2, 1'b0, '0);
    waitAck(5, got);
    checkOutput("mid_new_ack", got, 1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    collectGrants(2, 1, 1, "mid_new");

    checkOutput("never_both_writes", both_high, 0);
    checkOutput("write_values", bad_val, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
